// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx : stereo I2S (Philips format) audio transmitter with a sample FIFO.
//
// CPU writes push 16-bit {left, right} sample pairs into a FIFO. One pair is
// popped at the start of every 64-bit frame and shifted out MSB first, one bit
// after the word-select edge. If the FIFO is empty at a frame start, silence is
// sent and an underrun is reported.
//
// Ports
//   clk, nreset   system clock, asynchronous active-low reset
//   enable        1 = run the serial clocks and transmit, 0 = idle (outputs 0)
//   flush         1-cycle pulse: empty the FIFO and clear the underrun count
//   wr_data       sample pair {left[31:16], right[15:0]}, two's complement
//   wr_valid      push wr_data this cycle (accepted only while wr_ready)
//   wr_ready      FIFO not full
//   fifo_level    sample pairs currently stored
//   sample_req    registered, high while fifo_level < REQ_LEVEL
//   underrun      1-cycle pulse when a frame starts with the FIFO empty
//   underrun_cnt  saturating underrun count
//   i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdin   I2S bus (lrclk 0 = left slot)
// -----------------------------------------------------------------------------
module i2s_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int REQ_LEVEL  = 4,
  parameter int MCLK_HALF  = 2,
  parameter int SCLK_HALF  = 8
) (
  input  logic                            clk,
  input  logic                            nreset,
  input  logic                            enable,
  input  logic                            flush,
  input  logic [31:0]                     wr_data,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            sample_req,
  output logic                            underrun,
  output logic [7:0]                      underrun_cnt,
  output logic                            i2s_mclk,
  output logic                            i2s_sclk,
  output logic                            i2s_lrclk,
  output logic                            i2s_sdin
);

  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int MCW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int SCW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  localparam logic [LW-1:0]  DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]  REQ_L   = LW'(REQ_LEVEL);
  localparam logic [MCW-1:0] MCLK_TC = MCW'(MCLK_HALF - 1);
  localparam logic [SCW-1:0] SCLK_TC = SCW'(SCLK_HALF - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t          state_q, state_d;
  logic            restart;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_d;
  logic            push, pop, starve;

  logic [MCW-1:0]  mclk_cnt;
  logic [SCW-1:0]  sclk_cnt;
  logic [5:0]      bit_cnt, bit_nxt;
  logic            sclk_fall, frame_start;
  logic [31:0]     frame;
  logic [4:0]      left_idx, right_idx;
  logic            sdin_d;

  // ---------------------------------------------------------------------------
  // Run/idle control. Leaving idle restarts the serial clocks mid-high-phase of
  // bit 63 so the first SCLK falling edge opens a fresh frame.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE: if (enable) begin
        state_d = ST_RUN;
        restart = 1'b1;
      end
      ST_RUN:  if (!enable) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame timing strobes
  // ---------------------------------------------------------------------------
  assign sclk_fall   = (state_q == ST_RUN) && enable && (sclk_cnt == SCLK_TC) && i2s_sclk;
  assign bit_nxt     = bit_cnt + 6'd1;
  assign frame_start = sclk_fall && (bit_nxt == 6'd0);

  // ---------------------------------------------------------------------------
  // Sample FIFO. wr_ready depends only on the registered level.
  // ---------------------------------------------------------------------------
  assign wr_ready = (fifo_level != DEPTH_L);
  assign push     = wr_valid && wr_ready;
  assign pop      = frame_start && (fifo_level != '0);
  assign starve   = frame_start && (fifo_level == '0);

  always_comb begin
    level_d = fifo_level;
    if (flush) begin
      level_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_d = fifo_level + LW'(1);
        2'b01:   level_d = fifo_level - LW'(1);
        default: level_d = fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are valid, so clearing the data would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // ---------------------------------------------------------------------------
  // Status: request, underrun pulse and saturating count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sample_req   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      sample_req <= (level_d < REQ_L);
      underrun   <= starve;
      if (flush)                                underrun_cnt <= '0;
      else if (starve && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial data selection for the bit about to be presented. Left occupies
  // bits 1..16 and right bits 33..48 (one-bit delay after each LRCLK edge).
  // ---------------------------------------------------------------------------
  always_comb begin
    sdin_d    = 1'b0;
    left_idx  = 5'(6'd32 - bit_nxt);
    right_idx = 5'(6'd48 - bit_nxt);
    if (bit_nxt >= 6'd1 && bit_nxt <= 6'd16)       sdin_d = frame[left_idx];
    else if (bit_nxt >= 6'd33 && bit_nxt <= 6'd48) sdin_d = frame[right_idx];
  end

  // The frame register keeps its content across idle periods; bit 63 always
  // presents 0, so a stale word is never shifted out after a restart.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)          frame <= '0;
    else if (frame_start) frame <= pop ? mem[rd_ptr] : '0;
  end

  // ---------------------------------------------------------------------------
  // Serial clock generation and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mclk_cnt  <= '0;
      sclk_cnt  <= '0;
      bit_cnt   <= '0;
      i2s_mclk  <= 1'b0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdin  <= 1'b0;
    end else if (!enable) begin
      mclk_cnt  <= '0;
      sclk_cnt  <= '0;
      bit_cnt   <= '0;
      i2s_mclk  <= 1'b0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdin  <= 1'b0;
    end else if (restart) begin
      mclk_cnt  <= '0;
      sclk_cnt  <= '0;
      bit_cnt   <= 6'd63;
      i2s_mclk  <= 1'b0;
      i2s_sclk  <= 1'b1;
      i2s_lrclk <= 1'b1;
      i2s_sdin  <= 1'b0;
    end else begin
      if (mclk_cnt == MCLK_TC) begin
        mclk_cnt <= '0;
        i2s_mclk <= ~i2s_mclk;
      end else begin
        mclk_cnt <= mclk_cnt + MCW'(1);
      end

      if (sclk_cnt == SCLK_TC) begin
        sclk_cnt <= '0;
        i2s_sclk <= ~i2s_sclk;
      end else begin
        sclk_cnt <= sclk_cnt + SCW'(1);
      end

      if (sclk_fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt[5];
        i2s_sdin  <= sdin_d;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx : self-checking bench for i2s_tx.
//
// A behavioural model tracks time since the serial clocks started and a queue
// of stored sample pairs; every expected output is derived from that with plain
// arithmetic and compared against the DUT once per cycle on the falling clock
// edge. A capture process reassembles whole 64-bit frames from SCLK rising
// edges, which are compared against hand-written frame literals.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

  localparam int FIFO_DEPTH = 16;
  localparam int REQ_LEVEL  = 4;
  localparam int MCLK_HALF  = 2;
  localparam int SCLK_HALF  = 8;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          nreset;
  logic          enable;
  logic          flush;
  logic [31:0]   wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [LW-1:0] fifo_level;
  logic          sample_req;
  logic          underrun;
  logic [7:0]    underrun_cnt;
  logic          i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdin;

  i2s_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .REQ_LEVEL (REQ_LEVEL),
    .MCLK_HALF (MCLK_HALF),
    .SCLK_HALF (SCLK_HALF)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .enable      (enable),
    .flush       (flush),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .fifo_level  (fifo_level),
    .sample_req  (sample_req),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt),
    .i2s_mclk    (i2s_mclk),
    .i2s_sclk    (i2s_sclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdin    (i2s_sdin)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_q[$];
  bit          m_run;
  int          m_t;
  logic [31:0] m_fw;
  bit          m_und;
  int          m_ucnt;
  bit          m_sreq;
  bit          m_push_ok;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_q.delete();
      m_run  = 0;
      m_t    = 0;
      m_fw   = '0;
      m_und  = 0;
      m_ucnt = 0;
      m_sreq = 0;
    end else begin
      m_push_ok = wr_valid && (m_q.size() < FIFO_DEPTH);
      m_und = 0;
      if (!enable) begin
        m_run = 0;
        m_t   = 0;
      end else if (!m_run) begin
        m_run = 1;
        m_t   = 0;
      end else begin
        m_t++;
        if (m_t >= SCLK_HALF && ((m_t - SCLK_HALF) % (128 * SCLK_HALF)) == 0) begin
          if (m_q.size() > 0) begin
            m_fw = m_q.pop_front();
          end else begin
            m_fw  = '0;
            m_und = 1;
            if (m_ucnt < 255) m_ucnt++;
          end
        end
      end
      if (flush) begin
        m_q.delete();
        m_ucnt = 0;
      end else if (m_push_ok) begin
        m_q.push_back(wr_data);
      end
      m_sreq = (m_q.size() < REQ_LEVEL);
    end
  end

  function automatic int model_bit();
    if (!m_run)            return 0;
    if (m_t < SCLK_HALF)   return 63;
    return ((m_t - SCLK_HALF) / (2 * SCLK_HALF)) % 64;
  endfunction

  function automatic logic model_sdin(input int k, input logic [31:0] w);
    if (k >= 1 && k <= 16)  return w[32 - k];
    if (k >= 33 && k <= 48) return w[48 - k];
    return 1'b0;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame capture from the serial bus (receiver view: sample on SCLK rise)
  // ---------------------------------------------------------------------------
  logic [63:0] frames[$];
  logic [63:0] lrs[$];
  logic [63:0] sd_sh, lr_sh;
  int          cap_n;
  bit          seen_fall, prev_sclk;

  always @(negedge clk) begin
    if (!nreset || !enable) begin
      seen_fall = 0;
      prev_sclk = 0;
      cap_n     = 0;
    end else begin
      if (prev_sclk && !i2s_sclk) begin
        seen_fall = 1;
      end else if (!prev_sclk && i2s_sclk && seen_fall) begin
        sd_sh = {sd_sh[62:0], i2s_sdin};
        lr_sh = {lr_sh[62:0], i2s_lrclk};
        cap_n++;
        if (cap_n == 64) begin
          frames.push_back(sd_sh);
          lrs.push_back(lr_sh);
          cap_n = 0;
        end
      end
      prev_sclk = i2s_sclk;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int und_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    int k;
    k = model_bit();
    check("mclk",  i2s_mclk,  m_run ? 64'((m_t / MCLK_HALF) % 2) : 64'd0);
    check("sclk",  i2s_sclk,  m_run ? 64'(((m_t / SCLK_HALF) % 2) == 0) : 64'd0);
    check("lrclk", i2s_lrclk, m_run ? 64'(k >= 32) : 64'd0);
    check("sdin",  i2s_sdin,  m_run ? 64'(model_sdin(k, m_fw)) : 64'd0);
    check("fifo_level",   fifo_level,   64'(m_q.size()));
    check("wr_ready",     wr_ready,     64'(m_q.size() < FIFO_DEPTH));
    check("sample_req",   sample_req,   64'(m_sreq));
    check("underrun",     underrun,     64'(m_und));
    check("underrun_cnt", underrun_cnt, 64'(m_ucnt));
  endtask

  // One clock: compare on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    if (underrun) und_log.push_back(cyc);
    @(posedge clk);
    #2;
  endtask

  task automatic push_one(input logic [31:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [31:0] pushed[17];
  int          base, guard, ubase, en_cyc;

  initial begin
    nreset   = 1'b0;
    enable   = 1'b0;
    flush    = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;

    // Reset state
    #1;
    check("rst_wr_ready",   wr_ready,   1);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_sample_req", sample_req, 0);
    check("rst_sclk",       i2s_sclk,   0);
    repeat (3) tick();
    nreset = 1'b1;
    tick();
    check("req_after_reset", sample_req, 1);

    // Single known pair: one full frame on the wire
    push_one(32'hA5A53C3C);
    check("level_one", fifo_level, 1);
    enable = 1'b1;
    base   = frames.size();
    guard  = 0;
    while (frames.size() <= base && guard < 1200) begin
      tick();
      guard++;
    end
    check("frame_a_timeout", 64'(frames.size() > base), 1);
    if (frames.size() > base) begin
      check("frame_a_sdin",  frames[base], {1'b0, 16'hA5A5, 16'h0000, 16'h3C3C, 15'h0000});
      check("frame_a_lrclk", lrs[base],    64'h00000000_FFFFFFFF);
    end
    check("level_after_pop", fifo_level, 0);
    enable = 1'b0;
    tick();
    flush_pulse();

    // Fill past full while idle, then drain in order
    for (int i = 0; i < 17; i++) begin
      pushed[i] = $urandom;
      push_one(pushed[i]);
      check($sformatf("wr_ready_%0d", i), wr_ready, 64'(i < 15));
    end
    check("level_full", fifo_level, 16);
    enable = 1'b1;
    base   = frames.size();
    guard  = 0;
    while (frames.size() < base + 16 && guard < 17000) begin
      tick();
      guard++;
    end
    check("drain_timeout", 64'(frames.size() >= base + 16), 1);
    for (int i = 0; i < 16; i++) begin
      if (frames.size() > base + i) begin
        check($sformatf("drain_left_%0d", i),  frames[base + i][62:47], pushed[i][31:16]);
        check($sformatf("drain_right_%0d", i), frames[base + i][30:15], pushed[i][15:0]);
      end
    end
    check("level_drained", fifo_level, 0);
    enable = 1'b0;
    tick();
    flush_pulse();

    // Three frames with an empty FIFO
    enable = 1'b1;
    en_cyc = cyc;
    ubase  = und_log.size();
    repeat (3000) tick();
    enable = 1'b0;
    tick();
    check("underrun_pulses", und_log.size() - ubase, 3);
    if (und_log.size() >= ubase + 3) begin
      // enable is sampled on the next edge, the first SCLK fall follows 8 clk later
      check("underrun_first",   und_log[ubase] - en_cyc,             9);
      check("underrun_space_1", und_log[ubase + 1] - und_log[ubase],     1024);
      check("underrun_space_2", und_log[ubase + 2] - und_log[ubase + 1], 1024);
    end
    check("underrun_cnt_3", underrun_cnt, 3);
    flush_pulse();
    check("underrun_cnt_flushed", underrun_cnt, 0);

    // Push on the exact pop cycle with one entry stored
    push_one($urandom);
    enable = 1'b1;
    repeat (8) tick();
    wr_data  = $urandom;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("push_pop_level",    fifo_level, 1);
    check("push_pop_no_under", underrun,   0);
    enable = 1'b0;
    tick();

    // Push and flush together
    wr_data  = $urandom;
    wr_valid = 1'b1;
    flush    = 1'b1;
    tick();
    wr_valid = 1'b0;
    flush    = 1'b0;
    check("push_flush_level", fifo_level, 0);

    // sample_req threshold
    repeat (3) push_one($urandom);
    check("req_level3", sample_req, 1);
    push_one($urandom);
    check("req_level4", sample_req, 0);

    // Reset in the middle of a frame (around bit 20)
    enable = 1'b1;
    repeat (SCLK_HALF + 20 * 2 * SCLK_HALF + 2) tick();
    nreset = 1'b0;
    #1;
    check("midrst_mclk",  i2s_mclk,     0);
    check("midrst_sclk",  i2s_sclk,     0);
    check("midrst_lrclk", i2s_lrclk,    0);
    check("midrst_sdin",  i2s_sdin,     0);
    check("midrst_level", fifo_level,   0);
    check("midrst_ready", wr_ready,     1);
    check("midrst_req",   sample_req,   0);
    check("midrst_ucnt",  underrun_cnt, 0);
    enable = 1'b0;
    repeat (3) tick();
    nreset = 1'b1;
    tick();
    enable = 1'b1;
    en_cyc = cyc;
    ubase  = und_log.size();
    repeat (20) tick();
    check("restart_underrun", und_log.size() - ubase, 1);
    if (und_log.size() > ubase)
      check("restart_delay", und_log[ubase] - en_cyc, 9);
    enable = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
